// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
// Performs a WORDS x 16-bit add or subtract by feeding one shared external
// 16-bit combinational adder one slice at a time. The least-significant slice
// goes first, and the carry is chained between slices through carry_q.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_sub, req_cin      : operation select and add carry-in (cin ignored for sub)
//   req_a, req_b          : 16*WORDS-bit operands
//   add_a/add_b/add_cin   : current slice driven to the external adder
//   add_sum/add_cout      : combinational adder result for that slice
//   rsp_valid/rsp_ready   : response handshake
//   rsp_sum/cout/ovf      : result, final carry-out, signed overflow
//   busy                  : high while an operation is in RUN or DONE
module wide_add_sequencer #(
    parameter int WORDS = 4,
    parameter int IDXW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_sub,
    input  logic                  req_cin,
    input  logic [16*WORDS-1:0]   req_a,
    input  logic [16*WORDS-1:0]   req_b,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [16*WORDS-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf,
    output logic                  busy
);

    localparam int W = 16 * WORDS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;      // B already inverted for subtract
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    // Operands viewed as slices so the current slice can be picked by index.
    logic [15:0] a_sl [WORDS];
    logic [15:0] b_sl [WORDS];

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
        assign a_sl[gi] = a_q[16*gi +: 16];
        assign b_sl[gi] = b_q[16*gi +: 16];
    end

    logic [15:0] a_cur, b_cur;
    always_comb begin
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_cur = a_sl[i];
                b_cur = b_sl[i];
            end
        end
    end

    logic last_slice;
    assign last_slice = (idx_q == IDXW'(WORDS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_sub ? ~req_b : req_b;
                    // Subtract is A + ~B + 1, so the +1 rides in as carry-in.
                    carry_d = req_sub | req_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_cur;
                add_b   = b_cur;
                add_cin = carry_q;
                carry_d = add_cout;
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[16*i +: 16] = add_sum;
                    end
                end
                if (last_slice) begin
                    cout_d  = add_cout;
                    // Overflow: operands share a sign that the sum does not.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[15] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;
    assign rsp_ovf  = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

    localparam int WORDS = 4;
    localparam int IDXW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_sub = 1'b0;
    logic        req_cin = 1'b0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_sum;
    logic        rsp_cout, rsp_ovf, busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Model of the external 16-bit combinational adder.
    logic [16:0] adder_full;
    assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    assign add_sum    = adder_full[15:0];
    assign add_cout   = adder_full[16];

    wide_add_sequencer #(.WORDS(WORDS), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_cin   (req_cin),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  cins;   // add_cin seen in RUN cycle k at bit k
        logic [15:0] fb;     // add_b seen in the first RUN cycle
    } vec_t;

    // Drives one request from IDLE and captures what happens up to rsp_valid.
    // Called #1 after a clock edge. Request fields are scrambled right after
    // acceptance so any re-sampling would corrupt the result.
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic cin,
                         output int lat, output logic [3:0] cins,
                         output logic [15:0] first_b);
        int n;
        req_a = a; req_b = b; req_sub = sub; req_cin = cin;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = ~a; req_b = ~b; req_sub = ~sub; req_cin = ~cin;
        n = 0; cins = '0; first_b = '0;
        while (!rsp_valid && n < 20) begin
            if (n < 4) cins[n] = add_cin;
            if (n == 0) first_b = add_b;
            @(posedge clk); #1;
            n++;
        end
        lat = n + 1;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_a = 64'h1; req_b = 64'h1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
                add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0 ||
                rsp_sum !== 64'h0 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_cycle%0d: got rdy=%b busy=%b vld=%b a=%h b=%h cin=%b sum=%h co=%b ov=%b, expected rdy=1 busy=0 vld=0 all else 0",
                         c, req_ready, busy, rsp_valid, add_a, add_b, add_cin, rsp_sum, rsp_cout, rsp_ovf);
            end
        end
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_no_accept: got busy=%b rdy=%b, expected busy=0 rdy=1", busy, req_ready);
        end
        $display("reset: rdy=%b busy=%b vld=%b", req_ready, busy, rsp_valid);
    endtask

    task automatic test_arith();
        vec_t tbl[6];
        int lat;
        logic [3:0] cins;
        logic [15:0] fb;
        tbl[0] = '{"add_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                   64'h0000_0000_0001_0000, 1'b0, 1'b0, 4'b0010, 16'h0001};
        tbl[1] = '{"full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   64'h0, 1'b1, 1'b0, 4'b1110, 16'h0001};
        tbl[2] = '{"sub_5_7", 64'h5, 64'h7, 1'b1, 1'b1,
                   64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'b0001, 16'hFFF8};
        tbl[3] = '{"ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'b1110, 16'h0001};
        tbl[4] = '{"ovf_neg_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 4'b0001, 16'hFFFE};
        tbl[5] = '{"add_cin1", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b1,
                   64'h2345_6789_ABCD_F002, 1'b0, 1'b0, 4'b0001, 16'h1111};
        // Back-to-back: each request is issued in the first IDLE cycle after
        // the previous response handshake.
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, lat, cins, fb);
            vectors++;
            if (lat != 5) begin
                miscompares++;
                $display("FAIL %s_latency: got %0d, expected 5", tbl[i].name, lat);
            end
            vectors++;
            if (cins !== tbl[i].cins || fb !== tbl[i].fb) begin
                miscompares++;
                $display("FAIL %s_adder_drive: got cins=%b first_b=%h, expected cins=%b first_b=%h",
                         tbl[i].name, cins, fb, tbl[i].cins, tbl[i].fb);
            end
            vectors++;
            if (rsp_sum !== tbl[i].sum || rsp_cout !== tbl[i].cout || rsp_ovf !== tbl[i].ovf) begin
                miscompares++;
                $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                         tbl[i].name, rsp_sum, rsp_cout, rsp_ovf, tbl[i].sum, tbl[i].cout, tbl[i].ovf);
            end
            release_rsp();
            vectors++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_release: got vld=%b rdy=%b, expected vld=0 rdy=1",
                         tbl[i].name, rsp_valid, req_ready);
            end
            $display("op %s: sum=%h cout=%b ovf=%b lat=%0d", tbl[i].name, rsp_sum, rsp_cout, rsp_ovf, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0] cins;
        logic [15:0] fb;
        issue(64'h10, 64'h20, 1'b0, 1'b0, lat, cins, fb);
        for (int c = 0; c < 6; c++) begin
            // A pending request during DONE must be neither accepted nor sampled.
            req_valid = 1'b1; req_a = 64'hDEAD; req_b = 64'hBEEF;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 64'h30 || rsp_cout !== 1'b0 ||
                rsp_ovf !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got vld=%b sum=%h co=%b ov=%b rdy=%b busy=%b, expected vld=1 sum=30 co=0 ov=0 rdy=0 busy=1",
                         c, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, req_ready, busy);
            end
            @(posedge clk); #1;
        end
        release_rsp();
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_sum !== 64'h30) begin
            miscompares++;
            $display("FAIL handshake_no_accept: got busy=%b rdy=%b sum=%h, expected busy=0 rdy=1 sum=30",
                     busy, req_ready, rsp_sum);
        end
        req_valid = 1'b0;
        $display("backpressure: sum=%h held 6 cycles", rsp_sum);
    endtask

    task automatic test_abort();
        req_a = 64'hAAAA_BBBB_CCCC_DDDD; req_b = 64'h1; req_sub = 1'b0; req_cin = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (add_a !== 16'hBBBB || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_at_idx2: got add_a=%h busy=%b, expected add_a=bbbb busy=1", add_a, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 ||
            rsp_sum !== 64'h0 || add_a !== 16'h0) begin
            miscompares++;
            $display("FAIL abort_state: got vld=%b rdy=%b busy=%b sum=%h add_a=%h, expected vld=0 rdy=1 busy=0 sum=0 add_a=0",
                     rsp_valid, req_ready, busy, rsp_sum, add_a);
        end
        $display("abort: rdy=%b busy=%b sum=%h", req_ready, busy, rsp_sum);
    endtask

    task automatic test_after_abort();
        int lat;
        logic [3:0] cins;
        logic [15:0] fb;
        issue(64'h0001_0002_0003_0004, 64'h0010_0020_0030_FFFF, 1'b0, 1'b0, lat, cins, fb);
        vectors++;
        if (lat != 5 || rsp_sum !== 64'h0011_0022_0034_0003 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL after_abort: got lat=%0d sum=%h co=%b ov=%b, expected lat=5 sum=0011002200340003 co=0 ov=0",
                     lat, rsp_sum, rsp_cout, rsp_ovf);
        end
        release_rsp();
        $display("after_abort: sum=%h lat=%0d", rsp_sum, lat);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_abort();
        test_after_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle controller that performs WORDS×16-bit add/subtract by sequencing one shared external 16-bit lookahead adder slice-by-slice, least-significant slice first.
- Carry is chained between slices through an internal register.
- Requests arrive on a valid/ready handshake and results leave on a second valid/ready handshake.
- Sits between the ALU issue logic and the 16-bit adder block; the adder itself stays purely combinational.

Parameters:
WORDS, 4, number of 16-bit slices per operand (legal range 1..16; operand width = 16*WORDS)
IDXW, 4, width of slice index counter; must satisfy 2**IDXW >= WORDS

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1)
req_cin  input  1  carry-in for add; ignored when req_sub=1
req_a  input  16*WORDS  operand A
req_b  input  16*WORDS  operand B
add_a  output  16  slice of A to adder
add_b  output  16  slice of B (inverted for sub) to adder
add_cin  output  1  carry-in to adder
add_sum  input  16  adder sum (combinational from add_a/add_b/add_cin)
add_cout  input  1  adder carry-out
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_sum  output  16*WORDS  result
rsp_cout  output  1  final carry-out (for sub: 1 = no borrow)
rsp_ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Reset:
- state=IDLE, idx=0, carry=0, operand and result registers=0.
- Outputs: req_ready=1, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0, add_a=0, add_b=0, add_cin=0.
- rst wins over all other inputs in the same cycle.

FSM states: IDLE, RUN, DONE.

IDLE:
- req_ready=1.
- On req_valid&&req_ready:
  - Latch a_reg=req_a.
  - b_reg = req_sub ? ~req_b : req_b.
  - carry = req_sub ? 1 : req_cin.
  - idx=0; go to RUN.
- add_* outputs are driven 0.

RUN:
- req_ready=0.
- Drive add_a=a_reg[16*idx+:16], add_b=b_reg[16*idx+:16], add_cin=carry.
- On each clock edge: sum_reg[16*idx+:16] <= add_sum; carry <= add_cout.
- If idx==WORDS-1: compute flags from final slice; go to DONE. Otherwise idx <= idx+1.
- Exactly WORDS RUN cycles.

DONE:
- rsp_valid=1; rsp_sum, rsp_cout, rsp_ovf are held stable while rsp_ready=0.
- On rsp_ready: go to IDLE. rsp_valid drops the next cycle; result registers keep their values.
- No new request is accepted in the cycle of the response handshake.

Flags:
- rsp_cout = add_cout of the final slice.
- rsp_ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is the possibly inverted B.

Latency:
- Request accepted at edge T; RUN covers cycles T+1..T+WORDS; rsp_valid is high from cycle T+WORDS+1.
- Minimum issue interval: WORDS+2 cycles.

Boundary conditions:
- WORDS=1: single RUN cycle; idx stays 0.
- idx never exceeds WORDS-1.
- req_* inputs are don't-care outside IDLE and are never re-sampled.
- rst during RUN/DONE aborts the operation: next cycle IDLE, rsp_valid=0, partial result discarded (registers cleared).
- add_sum must settle within one cycle; the controller adds no pipeline stage.

Test Plan:
- Reset: hold rst 2 cycles with req_valid=1 -> req_ready=1, busy=0, rsp_valid=0, add_a/add_b/add_cin=0; no request accepted during reset.
- WORDS=4: A=0x0000_0000_0000_FFFF, B=0x1, cin=0 -> add_cin 0,1,0,0 over the 4 RUN cycles; rsp_sum=0x0000_0000_0001_0000, cout=0, ovf=0; rsp_valid exactly 5 cycles after accept.
- Full ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> rsp_sum=0, rsp_cout=1, rsp_ovf=0.
- Subtract: A=5, B=7, sub=1, req_cin=1 (ignored) -> first RUN cycle shows add_b=0xFFF8 and add_cin=1; rsp_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1 -> rsp_sum=0x8000_0000_0000_0000, ovf=1, cout=0. Then 0x8000_0000_0000_0000 - 1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Backpressure and abort:
  - Hold rsp_ready=0 for 6 cycles in DONE -> outputs stable, req_ready=0, busy=1.
  - Issue a new request; assert rst for 1 cycle while idx=2 -> next cycle IDLE, rsp_valid=0, req_ready=1.
  - A subsequent request completes correctly.
